// File: rtl/ram8_seq_if.sv
// Command, response and RAM8 pin bundle between the sequencer (master) and the
// command fabric / memory array (slave).
interface ram8_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [CNT_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic              mem_ld;
  logic [DATA_W-1:0] mem_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data,
    input  rsp_ready, mem_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output mem_addr, mem_in, mem_ld
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data,
    output rsp_ready, mem_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_addr, mem_in, mem_ld
  );
endinterface

// File: rtl/ram8_sequencer.sv
// Block-command master for an 8x16 RAM8 array: FILL, forward COPY and 16-bit SUM,
// one command at a time with a held response.
module ram8_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 4
) (
  input logic         clk,
  input logic         rst_n,
  ram8_seq_if.master  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;

  typedef enum logic [2:0] {IDLE, FILL, COPY_RD, COPY_WR, SUM, RESP} state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] src_q, src_n, dst_q, dst_n, addr_q, addr_n;
  logic [CNT_W-1:0]  len_q, len_n, idx_q, idx_n;
  logic [DATA_W-1:0] acc_q, acc_n, din_q, din_n, rdata_q, rdata_n;
  logic              ld_q, ld_n, rvalid_q, rvalid_n, rerr_q, rerr_n, rdy_q, rdy_n;
  logic              last_c;

  assign last_c = (idx_q == CNT_W'(len_q - CNT_W'(1)));

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      ld_q     <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_n;
      src_q    <= src_n;
      dst_q    <= dst_n;
      addr_q   <= addr_n;
      len_q    <= len_n;
      idx_q    <= idx_n;
      acc_q    <= acc_n;
      din_q    <= din_n;
      rdata_q  <= rdata_n;
      ld_q     <= ld_n;
      rvalid_q <= rvalid_n;
      rerr_q   <= rerr_n;
      rdy_q    <= rdy_n;
    end
  end

  // Next state and next output values
  always_comb begin
    state_n  = state_q;
    src_n    = src_q;
    dst_n    = dst_q;
    addr_n   = addr_q;
    len_n    = len_q;
    idx_n    = idx_q;
    acc_n    = acc_q;
    din_n    = din_q;
    rdata_n  = rdata_q;
    ld_n     = 1'b0;
    rvalid_n = rvalid_q;
    rerr_n   = rerr_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          src_n  = bus.cmd_src;
          dst_n  = bus.cmd_dst;
          len_n  = bus.cmd_len;
          idx_n  = '0;
          acc_n  = '0;
          addr_n = bus.cmd_src;
          if (bus.cmd_op == 2'b11 || bus.cmd_len > CNT_W'(DEPTH)) begin
            state_n  = RESP;
            rvalid_n = 1'b1;
            rerr_n   = 1'b1;
            rdata_n  = '0;
          end else if (bus.cmd_len == '0) begin
            state_n  = RESP;
            rvalid_n = 1'b1;
            rerr_n   = 1'b0;
            rdata_n  = '0;
          end else begin
            case (bus.cmd_op)
              OP_FILL: begin
                state_n = FILL;
                din_n   = bus.cmd_data;
                ld_n    = 1'b1;
              end
              OP_COPY: state_n = COPY_RD;
              OP_SUM:  state_n = SUM;
              default: state_n = IDLE;
            endcase
          end
        end
      end
      FILL: begin
        if (last_c) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
          rerr_n   = 1'b0;
          rdata_n  = DATA_W'(len_q);
        end else begin
          ld_n   = 1'b1;
          idx_n  = idx_q + CNT_W'(1);
          addr_n = addr_q + ADDR_W'(1);
        end
      end
      // Read word into the write-data register, then write it at the destination
      COPY_RD: begin
        din_n   = bus.mem_out;
        addr_n  = dst_q + ADDR_W'(idx_q);
        ld_n    = 1'b1;
        state_n = COPY_WR;
      end
      COPY_WR: begin
        if (last_c) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
          rerr_n   = 1'b0;
          rdata_n  = DATA_W'(len_q);
        end else begin
          idx_n   = idx_q + CNT_W'(1);
          addr_n  = src_q + ADDR_W'(idx_q + CNT_W'(1));
          state_n = COPY_RD;
        end
      end
      SUM: begin
        acc_n = acc_q + bus.mem_out;
        if (last_c) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
          rerr_n   = 1'b0;
          rdata_n  = acc_q + bus.mem_out;
        end else begin
          idx_n  = idx_q + CNT_W'(1);
          addr_n = addr_q + ADDR_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_n  = IDLE;
          rvalid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    rdy_n = (state_n == IDLE);
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_in    = din_q;
  assign bus.mem_ld    = ld_q;
endmodule

// File: tb/tb_ram8_sequencer.sv
// Directed bench for ram8_sequencer with a behavioural RAM8 array and a response
// scoreboard holding expected data, error flag and latency per command.
module tb_ram8_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram8_seq_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(4)) bus ();

  ram8_sequencer #(.DATA_W(16), .ADDR_W(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [15:0] mem [8];
  logic [15:0] mdl [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign bus.mem_out = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_ld) mem[bus.mem_addr] <= bus.mem_in;
  end

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: k+1, mode 1: all ones, mode 2: k
  task automatic preload(input int mode);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = 3'(k);
      pre_data = (mode == 0) ? 16'(k + 1) : (mode == 1) ? 16'hFFFF : 16'(k);
      mdl[k]   = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] src,
                         input logic [2:0] dst, input logic [3:0] len,
                         input logic [15:0] data, input int hold, output logic [15:0] got);
    exp_t        e;
    logic [2:0]  exp_ld[$];
    logic [2:0]  ld_seen[$];
    logic [15:0] acc;
    logic [15:0] held;
    int          n;
    bit          legal;

    legal = (op != 2'b11) && (len <= 4'd8);
    e.err = !legal;
    e.data = '0;
    e.lat = 1;
    acc = '0;
    if (legal && len != 0) begin
      for (int i = 0; i < int'(len); i++) begin
        case (op)
          2'b00: begin mdl[3'(int'(src) + i)] = data; exp_ld.push_back(3'(int'(src) + i)); end
          2'b01: begin
            mdl[3'(int'(dst) + i)] = mdl[3'(int'(src) + i)];
            exp_ld.push_back(3'(int'(dst) + i));
          end
          default: acc = acc + mdl[3'(int'(src) + i)];
        endcase
      end
      e.data = (op == 2'b10) ? acc : 16'(len);
      e.lat  = (op == 2'b01) ? 2 * int'(len) + 1 : int'(len) + 1;
    end
    sb.push_back(e);

    @(negedge clk);
    check({tag, " cmd_ready idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_src   = 3'($urandom);
        bus.cmd_len   = 4'($urandom);
        bus.cmd_data  = 16'($urandom);
      end
      if (bus.mem_ld) ld_seen.push_back(bus.mem_addr);
    end while (!bus.rsp_valid && n < 64);

    check({tag, " rsp_valid seen"}, 32'(bus.rsp_valid), 32'd1);
    e = sb.pop_front();
    check({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(e.data));
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(e.err));
    check({tag, " latency"}, 32'(n), 32'(e.lat));
    check({tag, " cmd_ready busy"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, " write count"}, 32'(ld_seen.size()), 32'(exp_ld.size()));
    for (int i = 0; i < exp_ld.size() && i < ld_seen.size(); i++)
      check($sformatf("%s write addr %0d", tag, i), 32'(ld_seen[i]), 32'(exp_ld[i]));
    got  = bus.rsp_data;
    held = bus.rsp_data;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s hold valid %0d", tag, i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("%s hold data %0d", tag, i), 32'(bus.rsp_data), 32'(held));
      check($sformatf("%s hold cmd_ready %0d", tag, i), 32'(bus.cmd_ready), 32'd0);
      check($sformatf("%s hold ld %0d", tag, i), 32'(bus.mem_ld), 32'd0);
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, " rsp_valid dropped"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " cmd_ready after"}, 32'(bus.cmd_ready), 32'd1);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s mem[%0d]", tag, k), 32'(mem[k]), 32'(mdl[k]));
  endtask

  initial begin
    logic [15:0] r;
    bit          saw_rsp;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset mem_ld", 32'(bus.mem_ld), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset mem_in", 32'(bus.mem_in), 32'd0);
    rst_n = 1'b1;

    preload(2);
    run_cmd("fill wrap", 2'b00, 3'd6, 3'd0, 4'd4, 16'hBEEF, 0, r);
    check("fill rsp len", 32'(r), 32'd4);

    preload(0);
    run_cmd("sum ramp", 2'b10, 3'd0, 3'd0, 4'd8, 16'h0, 0, r);
    check("sum ramp 36", 32'(r), 32'd36);

    preload(1);
    run_cmd("sum ones", 2'b10, 3'd0, 3'd0, 4'd8, 16'h0, 0, r);
    check("sum ones fff8", 32'(r), 32'hFFF8);

    preload(2);
    run_cmd("copy 0to4", 2'b01, 3'd0, 3'd4, 4'd4, 16'h0, 0, r);
    for (int k = 4; k < 8; k++)
      check($sformatf("copy dst const %0d", k), 32'(mem[k]), 32'(k - 4));
    run_cmd("copy overlap", 2'b01, 3'd0, 3'd1, 4'd3, 16'h0, 0, r);
    for (int k = 1; k < 4; k++)
      check($sformatf("overlap const %0d", k), 32'(mem[k]), 32'd0);

    run_cmd("illegal op", 2'b11, 3'd2, 3'd5, 4'd3, 16'h1234, 0, r);
    run_cmd("fill len9", 2'b00, 3'd0, 3'd0, 4'd9, 16'h5555, 0, r);
    run_cmd("copy len15", 2'b01, 3'd1, 3'd2, 4'd15, 16'h0, 0, r);
    run_cmd("sum len0", 2'b10, 3'd3, 3'd0, 4'd0, 16'h0, 0, r);
    run_cmd("fill len0", 2'b00, 3'd3, 3'd0, 4'd0, 16'hAAAA, 0, r);

    run_cmd("fill hold", 2'b00, 3'd0, 3'd0, 4'd2, 16'hC0DE, 5, r);
    run_cmd("sum wrap", 2'b10, 3'd5, 3'd0, 4'd5, 16'h0, 0, r);
    run_cmd("copy wrap", 2'b01, 3'd6, 3'd2, 4'd8, 16'h0, 0, r);

    // Reset after two FILL writes have committed
    preload(2);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_src   = 3'd0;
    bus.cmd_len   = 4'd8;
    bus.cmd_data  = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort ld before reset", 32'(bus.mem_ld), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort mem_ld async", 32'(bus.mem_ld), 32'd0);
    check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("abort no response", 32'(saw_rsp), 32'd0);
    check("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort mem[0]", 32'(mem[0]), 32'h1234);
    check("abort mem[1]", 32'(mem[1]), 32'h1234);
    check("abort mem[2]", 32'(mem[2]), 32'd2);
    check("abort mem[7]", 32'(mem[7]), 32'd7);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
